// File: rtl/pio_key_in.sv
// Avalon-MM input PIO: synchronises an external input bus, captures edges into a
// sticky write-1-to-clear register and raises a maskable interrupt.
module pio_key_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser; prev is the one-cycle-old copy used for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  always_comb begin
    edge_det = rise | fall;
    if (EDGE_TYPE == 0) edge_det = rise;
    else if (EDGE_TYPE == 1) edge_det = fall;
  end

  assign clear_bits = (wr_en && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge outranks a simultaneous clear so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= edge_det | (edge_capture & ~clear_bits);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync2;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  always_comb begin
    if (IRQ_TYPE == 0) irq = |(sync2 & irq_mask);
    else               irq = |(edge_capture & irq_mask);
  end

endmodule
